// File: rtl/keyword_gate.sv
// rtl/keyword_gate.sv - buffers one text frame while a keyword matcher inspects a copy, then forwards or drops it
//
// Parameters: DEPTH (buffer words, power of two), TIMEOUT (verdict wait cycles after tlast),
//             DROP_ON_MATCH (1: drop matched / forward unmatched, 0: inverse).
// Optional:   KEYWORD_GATE_STATS_EN enables the frames_passed / frames_dropped counters;
//             without it both outputs are tied to 0.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   s_axis_*                      upstream frame (tdata/tkeep/tvalid/tready/tlast/tuser)
//   k_axis_*                      combinational copy of each accepted beat for the matcher
//   match_sig, no_match_sig, ack  verdict levels in, one-cycle acknowledge out
//   m_axis_*                      forwarded frame, registered outputs
//   frames_passed, frames_dropped statistics
module keyword_gate #(
    parameter int DEPTH         = 32,
    parameter int TIMEOUT       = 1024,
    parameter int DROP_ON_MATCH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [63:0] k_axis_tdata,
    output logic [7:0]  k_axis_tkeep,
    output logic        k_axis_tvalid,
    input  logic        k_axis_tready,
    output logic        k_axis_tlast,
    output logic        k_axis_tuser,
    input  logic        match_sig,
    input  logic        no_match_sig,
    output logic        ack,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] frames_passed,
    output logic [15:0] frames_dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] LAST_WAIT  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, BUFFER, WAIT_VERDICT, FORWARD, DROP} state_t;

    state_t state, next_state;

    logic [72:0]   mem [DEPTH];   // {tuser, tkeep, tdata}
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          verdict_valid, verdict_match, oversize;
    logic [TW-1:0] timeout_cnt;

    logic in_window, new_verdict, eff_valid, eff_match, eff_oversize;
    logic accept, full, fwd_load, fwd_done;
    state_t resolved;

    assign in_window   = (state == BUFFER) || (state == WAIT_VERDICT);
    assign new_verdict = in_window && !verdict_valid && (match_sig || no_match_sig);
    // A verdict arriving in the same cycle as the tlast beat counts as already latched.
    assign eff_valid   = verdict_valid || new_verdict;
    assign eff_match   = verdict_valid ? verdict_match : match_sig;
    assign accept      = (state == BUFFER) && s_axis_tvalid && k_axis_tready;
    assign full        = (count == FULL_COUNT);
    assign eff_oversize = oversize || (accept && full);
    // Load the output register whenever it is empty or being drained this cycle.
    assign fwd_load    = (state == FORWARD) && (count != '0) && (!m_axis_tvalid || m_axis_tready);
    assign fwd_done    = (state == FORWARD) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_comb begin
        resolved = FORWARD;
        if (eff_oversize)
            resolved = DROP;
        else if (eff_match)
            resolved = (DROP_ON_MATCH != 0) ? DROP : FORWARD;
        else
            resolved = (DROP_ON_MATCH != 0) ? FORWARD : DROP;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:         next_state = BUFFER;
            BUFFER:       if (accept && s_axis_tlast)
                              next_state = eff_valid ? resolved : WAIT_VERDICT;
            WAIT_VERDICT: if (new_verdict)
                              next_state = resolved;
                          else if (timeout_cnt == LAST_WAIT)
                              next_state = DROP;
            FORWARD:      if (fwd_done)
                              next_state = IDLE;
            DROP:         next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        s_axis_tready = (state == BUFFER) && k_axis_tready;
        k_axis_tvalid = (state == BUFFER) && s_axis_tvalid;
        k_axis_tdata  = s_axis_tdata;
        k_axis_tkeep  = s_axis_tkeep;
        k_axis_tlast  = s_axis_tlast;
        k_axis_tuser  = s_axis_tuser;
        ack           = new_verdict;
    end

    // Buffer storage; beats beyond DEPTH are discarded and flag the frame oversize.
    always_ff @(posedge clk) begin
        if (accept && !full)
            mem[wr_ptr] <= {s_axis_tuser, s_axis_tkeep, s_axis_tdata};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            verdict_valid <= 1'b0;
            verdict_match <= 1'b0;
            oversize      <= 1'b0;
            timeout_cnt   <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= 1'b0;
        end else if (state == IDLE || state == DROP) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            verdict_valid <= 1'b0;
            verdict_match <= 1'b0;
            oversize      <= 1'b0;
            timeout_cnt   <= '0;
        end else begin
            if (accept) begin
                if (full) begin
                    oversize <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                end
            end
            if (new_verdict) begin
                verdict_valid <= 1'b1;
                verdict_match <= match_sig;
            end
            if (state == WAIT_VERDICT)
                timeout_cnt <= timeout_cnt + 1'b1;
            if (fwd_load) begin
                {m_axis_tuser, m_axis_tkeep, m_axis_tdata} <= mem[rd_ptr];
                m_axis_tlast  <= (count == (AW+1)'(1));
                m_axis_tvalid <= 1'b1;
                rd_ptr        <= rd_ptr + 1'b1;
                count         <= count - 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

`ifdef KEYWORD_GATE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_passed  <= '0;
            frames_dropped <= '0;
        end else begin
            if (fwd_done && frames_passed != 16'hFFFF)
                frames_passed <= frames_passed + 1'b1;
            if (next_state == DROP && state != DROP && frames_dropped != 16'hFFFF)
                frames_dropped <= frames_dropped + 1'b1;
        end
    end
`else
    assign frames_passed  = '0;
    assign frames_dropped = '0;
`endif

endmodule

// File: tb/tb_keyword_gate.sv
// tb/tb_keyword_gate.sv - directed self-checking bench for keyword_gate (DEPTH=4, TIMEOUT=16)
module tb_keyword_gate;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [63:0] k_axis_tdata;
    logic [7:0]  k_axis_tkeep;
    logic        k_axis_tvalid, k_axis_tready, k_axis_tlast, k_axis_tuser;
    logic        match_sig, no_match_sig, ack;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [15:0] frames_passed, frames_dropped;

    always #5 clk = ~clk;

    keyword_gate #(.DEPTH(4), .TIMEOUT(16), .DROP_ON_MATCH(1)) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .k_axis_tdata(k_axis_tdata), .k_axis_tkeep(k_axis_tkeep), .k_axis_tvalid(k_axis_tvalid),
        .k_axis_tready(k_axis_tready), .k_axis_tlast(k_axis_tlast), .k_axis_tuser(k_axis_tuser),
        .match_sig(match_sig), .no_match_sig(no_match_sig), .ack(ack),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .frames_passed(frames_passed), .frames_dropped(frames_dropped)
    );

    int checks = 0;
    int failures = 0;
    int s_cnt = 0, k_cnt = 0, ack_cnt = 0, m_valid_cnt = 0;
    logic [73:0] m_q[$];
    logic        prev_stall = 1'b0;
    logic [73:0] prev_word;
    int exp_passed = 0, exp_dropped = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beat i of an n-beat frame: {tuser, tlast, tkeep, tdata}
    function automatic logic [73:0] beat(input int base, input int i, input int n);
        logic [63:0] d;
        logic [7:0]  kp;
        logic        u;
        d  = 64'hA5A5_0000_0000_0000 | (64'(base) << 16) | 64'(i);
        kp = (i == n - 1) ? 8'h0F : 8'hFF;
        u  = i[0];
        return {u, (i == n - 1), kp, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int base, input int i, input int n);
        logic [73:0] w;
        logic hs;
        int budget;
        w = beat(base, i, n);
        {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata} = w;
        s_axis_tvalid = 1'b1;
        budget = 100;
        hs = 1'b0;
        while (!hs && budget > 0) begin
            @(negedge clk);
            hs = s_axis_tready;
            step();
            budget--;
        end
        if (!hs) chk("accept_timeout", hs, 1'b1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int budget;
        budget = 60;
        while (m_q.size() < n && budget > 0) begin
            step();
            budget--;
        end
    endtask

    task automatic check_frame(input string tag, input int base, input int n);
        logic [73:0] w;
        chk({tag, "_count"}, m_q.size(), n);
        for (int i = 0; i < n; i++) begin
            w = (m_q.size() > 0) ? m_q.pop_front() : 'x;
            chk($sformatf("%s_beat%0d", tag, i), w, beat(base, i, n));
        end
        m_q.delete();
    endtask

    always @(negedge clk) begin
        logic [73:0] cur;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            cur = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            if (prev_stall) begin
                chk("stall_valid", m_axis_tvalid, 1'b1);
                chk("stall_hold", cur, prev_word);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = cur;
            if (m_axis_tvalid && m_axis_tready) m_q.push_back(cur);
            if (m_axis_tvalid) m_valid_cnt++;
            if (s_axis_tvalid && s_axis_tready) s_cnt++;
            if (k_axis_tvalid && k_axis_tready) k_cnt++;
            if (ack) ack_cnt++;
        end
    end

    initial begin
        int s0, k0, mv0;
        logic [3:0] pat;
        reset = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        k_axis_tready = 1'b1; m_axis_tready = 1'b1;
        match_sig = 1'b0; no_match_sig = 1'b0;
        pat = 4'b1001;   // m_axis_tready per cycle, bit 0 first: 1,0,0,1

        // Reset values
        repeat (3) step();
        @(negedge clk);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_k_tvalid", k_axis_tvalid, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tlast", m_axis_tlast, 1'b0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_passed", frames_passed, 16'd0);
        chk("rst_dropped", frames_dropped, 16'd0);
        step();
        reset = 1'b0;

        // 3-beat frame, no_match one cycle after tlast -> forwarded
        for (int i = 0; i < 3; i++) drive_beat(1, i, 3);
        no_match_sig = 1'b1;
        @(negedge clk);
        chk("f1_ack_high", ack, 1'b1);
        step();
        no_match_sig = 1'b0;
        @(negedge clk);
        chk("f1_ack_low", ack, 1'b0);
        chk("f1_first_valid_delay", m_axis_tvalid, 1'b0);
        @(negedge clk);
        chk("f1_first_valid", m_axis_tvalid, 1'b1);
        step();
        wait_words(3);
        check_frame("f1", 1, 3);
        chk("f1_ack_cnt", ack_cnt, 1);
        exp_passed++;

        // 4-beat frame, match after beat 2 -> dropped, ack while buffering
        mv0 = m_valid_cnt;
        for (int i = 0; i < 2; i++) drive_beat(2, i, 4);
        match_sig = 1'b1;
        @(negedge clk);
        chk("f2_ack_high", ack, 1'b1);
        chk("f2_ack_in_buffer", s_axis_tready, 1'b1);
        step();
        match_sig = 1'b0;
        for (int i = 2; i < 4; i++) drive_beat(2, i, 4);
        repeat (5) step();
        chk("f2_m_silent", m_valid_cnt - mv0, 0);
        chk("f2_ack_cnt", ack_cnt, 2);
        exp_dropped++;

        // 6-beat frame into a 4-word buffer -> all beats taken, frame dropped
        s0 = s_cnt; k0 = k_cnt; mv0 = m_valid_cnt;
        for (int i = 0; i < 6; i++) drive_beat(3, i, 6);
        chk("f3_s_beats", s_cnt - s0, 6);
        chk("f3_k_beats", k_cnt - k0, 6);
        no_match_sig = 1'b1;
        @(negedge clk);
        chk("f3_ack_high", ack, 1'b1);
        step();
        no_match_sig = 1'b0;
        repeat (5) step();
        chk("f3_m_silent", m_valid_cnt - mv0, 0);
        exp_dropped++;

        // No verdict: DROP 16 cycles after tlast, back in BUFFER two cycles later
        mv0 = m_valid_cnt;
        for (int i = 0; i < 2; i++) drive_beat(4, i, 2);
        repeat (17) @(posedge clk);
        @(negedge clk);
        chk("f4_not_ready_idle", s_axis_tready, 1'b0);
        @(negedge clk);
        chk("f4_ready_again", s_axis_tready, 1'b1);
        chk("f4_no_ack", ack_cnt, 3);
        chk("f4_m_silent", m_valid_cnt - mv0, 0);
        exp_dropped++;
        step();

        // k_axis backpressure, verdict mid-frame, then FORWARD with tready 1,0,0,1
        s0 = s_cnt;
        k_axis_tready = 1'b0;
        {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata} = beat(5, 0, 4);
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        chk("f5_stall_s_tready", s_axis_tready, 1'b0);
        chk("f5_stall_k_tvalid", k_axis_tvalid, 1'b1);
        chk("f5_stall_k_tdata", k_axis_tdata, beat(5, 0, 4) & 74'hFFFF_FFFF_FFFF_FFFF);
        step();
        @(negedge clk);
        chk("f5_stall_s_tready2", s_axis_tready, 1'b0);
        step();
        k_axis_tready = 1'b1;
        drive_beat(5, 0, 4);
        drive_beat(5, 1, 4);
        no_match_sig = 1'b1;
        @(negedge clk);
        chk("f5_ack_high", ack, 1'b1);
        step();
        no_match_sig = 1'b0;
        drive_beat(5, 2, 4);
        drive_beat(5, 3, 4);
        chk("f5_s_beats", s_cnt - s0, 4);
        for (int c = 0; c < 40 && m_q.size() < 4; c++) begin
            m_axis_tready = pat[c % 4];
            step();
        end
        m_axis_tready = 1'b1;
        step();
        check_frame("f5", 5, 4);
        exp_passed++;

`ifdef KEYWORD_GATE_STATS_EN
        chk("stats_passed", frames_passed, 16'(exp_passed));
        chk("stats_dropped", frames_dropped, 16'(exp_dropped));
`else
        chk("stats_passed_off", frames_passed, 16'd0);
        chk("stats_dropped_off", frames_dropped, 16'd0);
`endif

        // Reset mid-frame abandons it; a 1-beat frame then forwards normally
        drive_beat(6, 0, 4);
        drive_beat(6, 1, 4);
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("f6_rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("f6_rst_s_tready", s_axis_tready, 1'b0);
        step();
        reset = 1'b0;
        mv0 = m_valid_cnt;
        repeat (10) step();
        chk("f6_m_silent", m_valid_cnt - mv0, 0);
        drive_beat(7, 0, 1);
        no_match_sig = 1'b1;
        @(negedge clk);
        chk("f7_ack_high", ack, 1'b1);
        step();
        no_match_sig = 1'b0;
        wait_words(1);
        step();
        check_frame("f7", 7, 1);
`ifdef KEYWORD_GATE_STATS_EN
        chk("stats_after_rst_passed", frames_passed, 16'd1);
        chk("stats_after_rst_dropped", frames_dropped, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keyword_gate.md
KEYWORD_GATE -- requirements
Module: keyword_gate

Interface
REQ-001 SHALL have parameter DEPTH, default 32: frame buffer depth in 64-bit words, power of two, 4..256.
REQ-002 SHALL have parameter TIMEOUT, default 1024: cycles to wait for a verdict after the buffered frame's tlast.
REQ-003 SHALL have parameter DROP_ON_MATCH, default 1: 1 = drop matched frames and forward unmatched ones; 0 = the inverse.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  64/8/1/1/1/1  upstream text frame.
REQ-007 k_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  64/8/1/1/1/1  copy of each frame beat sent to the keyword matcher.
REQ-008 match_sig, no_match_sig  in  1 each  verdict levels from the matcher.
REQ-009 ack  out  1  one-cycle pulse acknowledging a verdict.
REQ-010 m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  64/8/1/1/1/1  forwarded frame.
REQ-011 frames_passed, frames_dropped  out  16 each  statistics counters (see Configuration).

Function
REQ-012 SHALL implement states IDLE, BUFFER, WAIT_VERDICT, FORWARD, DROP.
REQ-013 IDLE: clear buffer pointers, latched verdict, oversize flag and timeout counter; go to BUFFER next cycle.
REQ-014 BUFFER: s_axis_tready = k_axis_tready.
- k_axis_tvalid = s_axis_tvalid; k_axis data fields = s_axis data fields, combinationally.
- k_axis_tvalid SHALL NOT depend on k_axis_tready.
REQ-015 A beat is accepted when s_axis_tvalid && s_axis_tready. It is written to the buffer only if the buffer is not full; otherwise the oversize flag is set and the beat is discarded.
REQ-016 In BUFFER and WAIT_VERDICT, the first cycle with match_sig or no_match_sig high while no verdict is latched SHALL latch the verdict and pulse ack for exactly one cycle.
- If both inputs are high in the same cycle, match wins.
REQ-017 Accepting the tlast beat moves the block to the next state:
- WAIT_VERDICT if no verdict is latched;
- otherwise directly to the resolved state (REQ-019).
REQ-018 WAIT_VERDICT: s_axis_tready = 0. Increment the timeout counter each cycle; reaching TIMEOUT resolves to DROP.
REQ-019 Resolution: oversize -> DROP. match -> DROP if DROP_ON_MATCH, else FORWARD. no_match -> FORWARD if DROP_ON_MATCH, else DROP.
REQ-020 FORWARD: output the buffered words in order on m_axis with registered outputs.
- First m_axis_tvalid appears 1 cycle after entering FORWARD.
- tlast is set on the final stored word; tkeep and tuser are stored per word.
- The output holds stable while m_axis_tvalid && !m_axis_tready.
REQ-021 FORWARD ends when the last word is accepted; the block returns to IDLE.
REQ-022 DROP: discard buffer contents in one cycle; return to IDLE.
REQ-023 s_axis_tready SHALL be 0 in all states except BUFFER; k_axis_tvalid and m_axis_tvalid SHALL be 0 outside BUFFER and FORWARD respectively.
REQ-024 Buffer count SHALL be log2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH; exactly DEPTH words are storable.
REQ-025 A verdict arriving outside BUFFER and WAIT_VERDICT SHALL be ignored, with no ack.

Reset
REQ-026 Reset SHALL force state IDLE and set the following outputs to 0:
- s_axis_tready, k_axis_tvalid, m_axis_tvalid, m_axis_tlast, ack;
- frames_passed, frames_dropped.
REQ-027 Reset mid-frame SHALL abandon the frame; no partial frame appears on m_axis afterward.

Configuration
REQ-028 With KEYWORD_GATE_STATS_EN defined:
- frames_passed increments on completion of FORWARD;
- frames_dropped increments on each entry to DROP;
- both saturate at 16'hFFFF.
Without the macro, both outputs are constant 0 and no counter logic exists.

Verification
REQ-029 3-beat frame; no_match_sig high 1 cycle after tlast; DROP_ON_MATCH=1 -> ack pulses once; the 3 beats appear on m_axis with identical tdata/tkeep; tlast is on beat 3.
REQ-030 4-beat frame; match_sig high after beat 2 -> ack pulses once in BUFFER; no m_axis_tvalid; frames_dropped=1 (macro defined).
REQ-031 DEPTH=4, 6-beat frame with no_match -> all 6 beats are accepted on s_axis and copied to k_axis; frame dropped; m_axis silent.
REQ-032 TIMEOUT=16, no verdict after tlast -> DROP 16 cycles after tlast; no ack; the next frame is accepted normally.
REQ-033 FORWARD with m_axis_tready toggling 1,0,0,1 -> data held during stalls; no beats lost or duplicated; k_axis_tready low stalls s_axis_tready in BUFFER.
